// File: rtl/fir_frame_sequencer.sv
// Frame sequencer around an external FIR: feeds a frame of samples plus TAPS-1 flush zeros,
// forwards the expected number of results, and reports completion or a drain timeout.
module fir_frame_sequencer #(
  parameter int DATA_WL = 12,
  parameter int OUT_WL  = 12,
  parameter int TAPS    = 15,
  parameter int LEN_WL  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_WL-1:0]  frame_len,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  input  logic [DATA_WL-1:0] src_data,
  input  logic               src_valid,
  output logic               src_ready,
  output logic [DATA_WL-1:0] fir_data_in,
  output logic               fir_in_valid,
  input  logic [OUT_WL-1:0]  fir_data_out,
  input  logic               fir_out_valid,
  output logic [OUT_WL-1:0]  res_data,
  output logic               res_valid,
  output logic               res_last
);

  localparam int CW = LEN_WL + 1;
  localparam int FW = (TAPS > 2) ? $clog2(TAPS - 1) : 1;
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] FLUSH_N    = CW'(TAPS - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'((TAPS > 1) ? TAPS - 2 : 0);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_len, r_in_cnt, r_out_cnt;
  logic [FW-1:0] r_flush_cnt;
  logic [IW-1:0] r_idle_cnt;
  logic          r_timed_out;

  logic [CW-1:0] w_total, w_in_inc, w_out_inc;
  logic          w_active, w_accept, w_fwd, w_last_in, w_drain_full, w_idle_expire;

  assign w_total      = r_len + FLUSH_N;
  assign w_in_inc     = r_in_cnt + 1'b1;
  assign w_out_inc    = r_out_cnt + 1'b1;
  assign src_ready    = (r_state == RUN) && (r_in_cnt < r_len);
  assign w_accept     = src_valid && src_ready;
  assign w_last_in    = w_accept && (w_in_inc == r_len);
  assign w_active     = (r_state == RUN) || (r_state == FLUSH) || (r_state == DRAIN);
  assign w_fwd        = w_active && fir_out_valid && (r_out_cnt < w_total);
  assign w_drain_full = (r_out_cnt == w_total);
  assign w_idle_expire = (r_state == DRAIN) && !fir_out_valid && (r_idle_cnt == IDLE_LAST);

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign err_timeout = (r_state == DONE) && r_timed_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (frame_len == '0) ? DONE : RUN;
      RUN:     if (w_last_in) w_next = (TAPS > 1) ? FLUSH : DRAIN;
      FLUSH:   if (r_flush_cnt == FLUSH_LAST) w_next = DRAIN;
      DRAIN:   if (w_drain_full || w_idle_expire) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len        <= '0;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_flush_cnt  <= '0;
      r_idle_cnt   <= '0;
      r_timed_out  <= 1'b0;
      fir_data_in  <= '0;
      fir_in_valid <= 1'b0;
      res_data     <= '0;
      res_valid    <= 1'b0;
      res_last     <= 1'b0;
    end else begin
      res_valid    <= w_fwd;
      res_last     <= w_fwd && (w_out_inc == w_total);
      fir_in_valid <= 1'b0;
      if (w_fwd) begin
        res_data  <= fir_data_out;
        r_out_cnt <= w_out_inc;
      end
      // Idle cycles are counted from FLUSH onward so a stall that begins
      // before DRAIN still times out TIMEOUT cycles after the last result.
      if ((r_state == FLUSH) || (r_state == DRAIN)) begin
        if (fir_out_valid)             r_idle_cnt <= '0;
        else if (r_idle_cnt != IDLE_LAST) r_idle_cnt <= r_idle_cnt + 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_len       <= {1'b0, frame_len};
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_flush_cnt <= '0;
            r_idle_cnt  <= '0;
            r_timed_out <= 1'b0;
          end
        end
        RUN: begin
          r_idle_cnt <= '0;
          if (w_accept) begin
            fir_data_in  <= src_data;
            fir_in_valid <= 1'b1;
            r_in_cnt     <= w_in_inc;
          end
        end
        FLUSH: begin
          fir_data_in  <= '0;
          fir_in_valid <= 1'b1;
          r_flush_cnt  <= r_flush_cnt + 1'b1;
        end
        DRAIN: begin
          if (w_idle_expire && !w_drain_full) r_timed_out <= 1'b1;
        end
        DONE: begin
          r_in_cnt    <= '0;
          r_out_cnt   <= '0;
          r_flush_cnt <= '0;
          r_idle_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Directed bench for fir_frame_sequencer with a latency-3 echo FIR model.
module tb_fir_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] frame_len;
  logic        busy, done, err_timeout;
  logic [11:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic [11:0] fir_data_in;
  logic        fir_in_valid;
  logic [11:0] fir_data_out;
  logic        fir_out_valid;
  logic [11:0] res_data;
  logic        res_valid, res_last;

  fir_frame_sequencer #(.DATA_WL(12), .OUT_WL(12), .TAPS(15), .LEN_WL(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .fir_data_in(fir_data_in), .fir_in_valid(fir_in_valid),
    .fir_data_out(fir_data_out), .fir_out_valid(fir_out_valid),
    .res_data(res_data), .res_valid(res_valid), .res_last(res_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // controls written by the main initial block only
  logic clr = 1'b0;
  int   src_mode = 0;
  int   sup_after = 0;
  logic inj = 1'b0;

  // state owned by the negedge process
  int   cyc = 0;
  int   n_in, n_zero, n_res, n_last, last_idx, n_done, n_err, n_busy, n_fov;
  int   idle_run, idle_at_done, done_cyc, last_cyc, src_idx, mdl_out;
  int   in_cyc[32];
  logic [11:0] in_dat[32];
  logic [11:0] res_dat[32];
  logic [11:0] smp[4] = '{12'h101, 12'h2F3, 12'h800, 12'h7FF};
  logic [2:0]  pv;
  logic [11:0] pd[3];
  logic tog, acc_pending;

  always @(negedge clk) begin
    cyc++;
    if (clr) begin
      n_in = 0; n_zero = 0; n_res = 0; n_last = 0; last_idx = 0; n_done = 0;
      n_err = 0; n_busy = 0; n_fov = 0; idle_run = 0; idle_at_done = -1;
      done_cyc = 0; last_cyc = 0; src_idx = 0; mdl_out = 0;
      pv = '0; tog = 1'b0; acc_pending = 1'b0;
      src_valid = 1'b0; src_data = '0; fir_out_valid = 1'b0; fir_data_out = '0;
    end else begin
      if (fir_in_valid) begin
        if (n_in < 32) begin in_cyc[n_in] = cyc; in_dat[n_in] = fir_data_in; end
        if (fir_data_in == '0) n_zero++;
        n_in++;
      end
      if (res_valid) begin
        if (n_res < 32) res_dat[n_res] = res_data;
        n_res++;
        if (res_last) begin n_last++; last_idx = n_res; last_cyc = cyc; end
      end
      if (busy) n_busy++;
      if (fir_out_valid) begin idle_run = 0; n_fov++; end
      else idle_run++;
      if (done) begin
        n_done++; done_cyc = cyc; idle_at_done = idle_run;
        if (err_timeout) n_err++;
      end
      if (acc_pending) src_idx++;
      tog = ~tog;
      src_valid = (src_mode == 1) || ((src_mode == 2) && tog);
      src_data = smp[(src_idx < 4) ? src_idx : 3];
      acc_pending = src_valid && src_ready;
      pv = {pv[1:0], fir_in_valid};
      pd[2] = pd[1]; pd[1] = pd[0]; pd[0] = fir_data_in;
      fir_out_valid = 1'b0;
      if (pv[2] && ((sup_after == 0) || (mdl_out < sup_after))) begin
        fir_out_valid = 1'b1;
        fir_data_out = pd[2];
        mdl_out++;
      end
      if (inj) fir_out_valid = 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    tick(); tick();
    clr = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    start = 1'b1;
    frame_len = 16'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && n_done == 0; i++) tick();
    check("done_seen", int'(n_done != 0), 1);
    tick(); tick(); tick();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; frame_len = '0;
    clear_mon();
    check("rst_ctl", int'({busy, done, err_timeout, src_ready, fir_in_valid, res_valid, res_last}), 0);
    check("rst_data", int'({fir_data_in, res_data}), 0);
    rst = 1'b1;
    tick();

    // len=4, source always valid
    src_mode = 1;
    clear_mon();
    pulse_start(4);
    wait_done();
    check("t1_in", n_in, 18);
    check("t1_zero", n_zero, 14);
    check("t1_acc_span", in_cyc[3] - in_cyc[0], 3);
    check("t1_flush_span", in_cyc[17] - in_cyc[4], 13);
    check("t1_res", n_res, 18);
    check("t1_last_idx", last_idx, 18);
    check("t1_n_last", n_last, 1);
    check("t1_done_lat", done_cyc - last_cyc, 1);
    check("t1_done", n_done, 1);
    check("t1_err", n_err, 0);
    check("t1_r0", int'(res_dat[0]), 'h101);
    check("t1_r3", int'(res_dat[3]), 'h7FF);
    check("t1_r4", int'(res_dat[4]), 0);

    // len=4, source toggling
    src_mode = 2;
    clear_mon();
    pulse_start(4);
    wait_done();
    check("t2_gap", in_cyc[1] - in_cyc[0], 2);
    check("t2_gap2", in_cyc[3] - in_cyc[2], 2);
    for (int k = 0; k < 4; k++) check("t2_data", int'(in_dat[k]), int'(smp[k]));
    check("t2_in", n_in, 18);
    check("t2_res", n_res, 18);

    // len=0
    src_mode = 1;
    clear_mon();
    pulse_start(0);
    wait_done();
    check("t3_busy", n_busy, 1);
    check("t3_done", n_done, 1);
    check("t3_in", n_in, 0);
    check("t3_err", n_err, 0);

    // len=2 with FIR going silent after the 5th result
    sup_after = 5;
    clear_mon();
    pulse_start(2);
    wait_done();
    check("t4_res", n_res, 5);
    check("t4_last", n_last, 0);
    check("t4_err", n_err, 1);
    check("t4_idle", idle_at_done, 64);
    sup_after = 0;

    // second start during RUN is ignored
    clear_mon();
    pulse_start(4);
    tick();
    pulse_start(1);
    wait_done();
    check("t5_res", n_res, 18);
    check("t5_done", n_done, 1);
    // stray FIR results while idle are dropped
    clear_mon();
    inj = 1'b1; tick(); inj = 1'b0; tick();
    inj = 1'b1; tick(); inj = 1'b0; tick(); tick(); tick();
    check("t5_fov", n_fov, 2);
    check("t5_idle_res", n_res, 0);

    // reset during FLUSH
    clear_mon();
    pulse_start(4);
    for (int i = 0; i < 100 && n_zero < 3; i++) tick();
    check("t6_in_flush", int'(n_zero >= 3), 1);
    #1 rst = 1'b0;
    #1;
    check("t6_ctl", int'({busy, done, err_timeout, src_ready, fir_in_valid, res_valid, res_last}), 0);
    check("t6_data", int'({fir_data_in, res_data}), 0);
    tick(); tick(); tick();
    check("t6_nodone", n_done, 0);
    rst = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    clear_mon();
    pulse_start(1);
    wait_done();
    check("t6_res", n_res, 15);
    check("t6_last_idx", last_idx, 15);
    check("t6_done", n_done, 1);
    check("t6_err", n_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
